// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: walks the columns, debounces the first row seen
// low, and reports the pressed key as a hex nibble with a one-cycle strobe.
// Optional auto-repeat while a key is held: define KEYPAD_TYPEMATIC_EN.
module keypad_scan_decoder #(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_CYCLES   = 6000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DwellW = $clog2(SCAN_DIV);
   localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
   localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_t;

   state_t            state;
   logic [3:0]        rows_meta;
   logic [3:0]        rs;
   logic [1:0]        col_idx;
   logic [1:0]        next_col;
   logic [1:0]        row_sel;
   logic [1:0]        low_row;
   logic [DwellW-1:0] dwell;
   logic [DebW-1:0]   cnt;

`ifdef KEYPAD_TYPEMATIC_EN
   localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
   logic [RepW-1:0] rep_cnt;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^REPEAT_CYCLES;
`endif

   // Map a (row, column) position onto the legend printed on the keypad.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Two-flop synchronizer for the asynchronous row lines; idle rows read high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rows_meta <= 4'hF;
         rs        <= 4'hF;
      end else begin
         rows_meta <= rows;
         rs        <= rows_meta;
      end
   end

   // Lowest-index low row wins when several rows are pulled low together.
   always_comb begin
      low_row = 2'd3;
      if (!rs[0])      low_row = 2'd0;
      else if (!rs[1]) low_row = 2'd1;
      else if (!rs[2]) low_row = 2'd2;
   end

   assign next_col = col_idx + 2'd1;

   // Scan/debounce/hold/release state machine with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StScan;
         col_idx   <= 2'd0;
         cols      <= 4'b1110;
         row_sel   <= 2'd0;
         dwell     <= '0;
         cnt       <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
         rep_cnt   <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         unique case (state)
            StScan: begin
               // Rows are only looked at on the last dwell cycle so they can settle.
               if (dwell == DwellLast) begin
                  dwell <= '0;
                  if (rs == 4'hF) begin
                     col_idx <= next_col;
                     cols    <= ~(4'b0001 << next_col);
                  end else begin
                     row_sel <= low_row;
                     cnt     <= '0;
                     state   <= StDebounce;
                  end
               end else begin
                  dwell <= dwell + DwellW'(1);
               end
            end
            StDebounce: begin
               if (rs[row_sel]) begin
                  state   <= StScan;
                  cnt     <= '0;
                  dwell   <= '0;
                  col_idx <= next_col;
                  cols    <= ~(4'b0001 << next_col);
               end else if (cnt == DebLast) begin
                  cnt       <= '0;
                  key_code  <= key_map(row_sel, col_idx);
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  state     <= StHeld;
`ifdef KEYPAD_TYPEMATIC_EN
                  rep_cnt   <= '0;
`endif
               end else begin
                  cnt <= cnt + DebW'(1);
               end
            end
            StHeld: begin
               if (rs[row_sel]) begin
                  state <= StRelease;
                  cnt   <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
                  rep_cnt <= '0;
               end else if (rep_cnt == RepLast) begin
                  rep_cnt   <= '0;
                  key_valid <= 1'b1;
               end else begin
                  rep_cnt <= rep_cnt + RepW'(1);
`endif
               end
            end
            StRelease: begin
               if (!rs[row_sel]) begin
                  // Release bounce: treat the key as still held.
                  state <= StHeld;
                  cnt   <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
                  rep_cnt <= '0;
`endif
               end else if (cnt == DebLast) begin
                  cnt      <= '0;
                  key_held <= 1'b0;
                  state    <= StScan;
                  dwell    <= '0;
                  col_idx  <= next_col;
                  cols     <= ~(4'b0001 << next_col);
               end else begin
                  cnt <= cnt + DebW'(1);
               end
            end
            default: state <= StScan;
         endcase
      end
   end

endmodule

// File: doc/keypad_scan_decoder.md
Name: keypad_scan_decoder

Overview:
- Scans a 4x4 matrix keypad: drives columns one at a time, senses rows, debounces, encodes the pressed key to a hex nibble.
- Input-side counterpart of the hex-to-7-segment display path.
- key_code feeds the display decoder; key_valid marks each new accepted press.
- Runs on the HSOSC-derived system clock.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell); minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release; minimum 1.
- REPEAT_CYCLES, 6000000: auto-repeat interval. Used only with KEYPAD_TYPEMATIC_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rows  input  4  keypad row lines, active-low (external pull-ups), asynchronous to clk
- cols  output  4  column drive, active-low, exactly one bit low at any time
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when key_code is updated by an accepted press
- key_held  output  1  high while an accepted key remains pressed (HELD/RELEASE states)

Behaviour:
- Reset values: cols=4'b1110, key_code=4'h0, key_valid=0, key_held=0. State=SCAN, column index=0, all counters=0.
- rows pass through a 2-flop synchronizer; all logic below uses the synchronized value rs. Pin-to-rs latency is 2 cycles.
- Key map, row r / col c, r=0..3:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- The dwell counter counts 0..SCAN_DIV-1 per column. rs is sampled only on the last dwell cycle, which allows settling after a column change.
- SCAN:
  - Sample with rs==4'hF: advance column index (3 wraps to 0) and update cols.
  - Sample with any rs bit low: capture row (lowest-index low row wins when several are low) and current column, freeze cols, go to DEBOUNCE.
- DEBOUNCE:
  - The counter increments each cycle the captured row bit is low.
  - If the captured row reads high before the count completes: abandon, return to SCAN, advance to next column, no output.
  - On reaching DEBOUNCE_CYCLES: key_code <= map(row,col), key_valid=1 for exactly that one cycle, key_held=1, go to HELD.
  - key_valid therefore asserts DEBOUNCE_CYCLES+1 cycles after the capturing sample cycle.
- HELD:
  - cols stay frozen. Other rows and keys are ignored (no rollover, no ghost handling).
  - Captured row going high moves to RELEASE with the counter cleared.
- RELEASE:
  - Counts cycles with the captured row high.
  - Row low again before DEBOUNCE_CYCLES: back to HELD, no new key_valid.
  - Count complete: key_held=0, go to SCAN, resume at next column.
- key_code holds its value until the next accepted press; it is never cleared except by reset.
- key_valid never asserts in SCAN, HELD or RELEASE (except auto-repeat, see below).
- Reset asserted mid-operation, in any state: all outputs and state return to reset values immediately (asynchronous). A key still held at reset release is re-detected from SCAN as a new press.
- All counters saturate/clear explicitly; no wrap-around while in DEBOUNCE or RELEASE.

Optional Feature:
- Macro: KEYPAD_TYPEMATIC_EN.
- Defined: in HELD, a repeat counter runs from the accepting cycle. Every REPEAT_CYCLES cycles it pulses key_valid for one cycle with key_code unchanged. The counter clears on leaving HELD; a RELEASE-to-HELD bounce restarts it from 0.
- Undefined: exactly one key_valid per accepted press; no repeat logic synthesized.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32):
- Reset, no keys, 64 cycles -> cols walks 1110,1101,1011,0111,1110, each for 4 cycles; key_valid never 1; key_code=0.
- Press key at row1/col2 held 40 cycles -> cols frozen at 1011; one key_valid pulse with key_code=4'h6; key_held=1; after release+8 stable cycles key_held=0 and scanning resumes at col 3.
- Press row3/col1 with 3-cycle bounce (low 3, high 1, low steady) -> no key_valid during bounce; single pulse with key_code=4'h0 after 8 stable low cycles.
- Release glitch: while HELD on key 'A' (r0/c3), rows high 4 cycles then low -> no second key_valid; key_held stays 1.
- Reset asserted during DEBOUNCE on key '9' -> outputs return to reset values at once; with key still held, '9' is accepted again after reset release (one pulse, key_code=4'h9).
- KEYPAD_TYPEMATIC_EN defined, key 'C' held 100 cycles past accept -> key_valid pulses at accept, +32, +64, +96; key_code=4'hC throughout.
